// File: rtl/mux_route_reg_pkg.sv
// Shared definitions for mux_route_reg: index-width helper, slot states, counter width.
package mux_pkg;

  localparam int CNT_W = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  // ceil(log2(n)) but never below 1, so a select port always has at least one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/mux_out_slot.sv
// Single-entry output holding register with valid/ready handshake.
// With MUX_ROUTE_CNT_EN defined, also counts loads into this slot (wrapping).
module mux_out_slot
  import mux_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [SIZE-1:0]  data_i,
  input  logic             out_ready_i,
  output logic [SIZE-1:0]  data_o,
  output logic             valid_o,
  output logic             ready_o
`ifdef MUX_ROUTE_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_o
`endif
);

  slot_state_e     state_q, state_d;
  logic [SIZE-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= EMPTY;
    else          state_q <= state_d;
  end

  // A load wins over a consume, so a same-cycle consume+load keeps the slot full.
  always_comb begin
    state_d = state_q;
    if (load_i)           state_d = FULL;
    else if (out_ready_i) state_d = EMPTY;
  end

  // Data is held across EMPTY so displays never blank.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)    data_q <= '0;
    else if (load_i) data_q <= data_i;
  end

  assign data_o  = data_q;
  assign valid_o = (state_q == FULL);
  assign ready_o = (state_q == EMPTY) | out_ready_i;

`ifdef MUX_ROUTE_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)    cnt_q <= '0;
    else if (load_i) cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/mux_route_reg.sv
// Registered N_IN -> N_OUT router: source mux, destination decode, ready mux, drop pulse.
// Optional per-slot transfer counters on cnt_ when MUX_ROUTE_CNT_EN is defined.
module mux_route_reg
  import mux_pkg::*;
#(
  parameter  int SIZE  = 4,
  parameter  int N_IN  = 2,
  parameter  int N_OUT = 2,
  localparam int SEL_W = clog2(N_IN),
  localparam int DST_W = clog2(N_OUT)
) (
  input  logic                    clk_,
  input  logic                    rst_n_,
  input  logic [N_IN*SIZE-1:0]    inp_,
  input  logic [SEL_W-1:0]        sel_,
  input  logic [DST_W-1:0]        dst_,
  input  logic                    valid_,
  output logic                    ready_,
  output logic [N_OUT*SIZE-1:0]   out_,
  output logic [N_OUT-1:0]        out_valid_,
  input  logic [N_OUT-1:0]        out_ready_,
  output logic                    drop_
`ifdef MUX_ROUTE_CNT_EN
  ,
  output logic [N_OUT*CNT_W-1:0]  cnt_
`endif
);

  logic [SIZE-1:0]              src_data;
  logic [N_OUT-1:0][SIZE-1:0]   slot_data;
  logic [N_OUT-1:0]             slot_vld, slot_rdy, slot_load;
  logic                         dst_ok, accept, drop_q;

  // Out-of-range sel_ yields all-zero data.
  always_comb begin
    src_data = '0;
    for (int k = 0; k < N_IN; k++)
      if (32'(sel_) == 32'(k)) src_data = inp_[k*SIZE +: SIZE];
  end

  assign dst_ok = (32'(dst_) < 32'(N_OUT));

  // Out-of-range dst_ is always ready; such requests are swallowed.
  always_comb begin
    ready_ = 1'b1;
    for (int j = 0; j < N_OUT; j++)
      if (32'(dst_) == 32'(j)) ready_ = slot_rdy[j];
  end

  assign accept = valid_ & ready_;

  always_ff @(posedge clk_ or negedge rst_n_) begin
    if (!rst_n_) drop_q <= 1'b0;
    else         drop_q <= accept & ~dst_ok;
  end

  assign drop_ = drop_q;

`ifdef MUX_ROUTE_CNT_EN
  logic [N_OUT-1:0][CNT_W-1:0] slot_cnt;
  assign cnt_ = slot_cnt;
`endif

  for (genvar j = 0; j < N_OUT; j++) begin : g_slot
    assign slot_load[j] = accept & (32'(dst_) == 32'(j));

    mux_out_slot #(.SIZE(SIZE)) u_slot (
      .clk_i       (clk_),
      .rst_n_i     (rst_n_),
      .load_i      (slot_load[j]),
      .data_i      (src_data),
      .out_ready_i (out_ready_[j]),
      .data_o      (slot_data[j]),
      .valid_o     (slot_vld[j]),
      .ready_o     (slot_rdy[j])
`ifdef MUX_ROUTE_CNT_EN
      ,
      .cnt_o       (slot_cnt[j])
`endif
    );
  end

  assign out_       = slot_data;
  assign out_valid_ = slot_vld;

endmodule

// File: tb/tb_mux_route_reg.sv
// Bench for mux_route_reg: a 2x2 and a 3x3 instance driven by directed then random stimulus,
// checked every cycle against a slot-level behavioural model.
module tb_mux_route_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit run = 1'b0;

  // index 0: SIZE=4,N_IN=2,N_OUT=2   index 1: SIZE=4,N_IN=3,N_OUT=3
  logic [11:0] t_inp [2];
  logic [1:0]  t_sel [2];
  logic [1:0]  t_dst [2];
  logic        t_val [2];
  logic [2:0]  t_ordy[2];

  logic [7:0]  inp_a;  logic [11:0] inp_b;
  logic [0:0]  sel_a;  logic [1:0]  sel_b;
  logic [0:0]  dst_a;  logic [1:0]  dst_b;
  logic [1:0]  ordy_a; logic [2:0]  ordy_b;
  logic [7:0]  out_a;  logic [11:0] out_b;
  logic [1:0]  vld_a;  logic [2:0]  vld_b;
  logic        rdy_a, rdy_b, drop_a, drop_b;

  assign inp_a  = t_inp[0][7:0];  assign inp_b  = t_inp[1];
  assign sel_a  = t_sel[0][0:0];  assign sel_b  = t_sel[1];
  assign dst_a  = t_dst[0][0:0];  assign dst_b  = t_dst[1];
  assign ordy_a = t_ordy[0][1:0]; assign ordy_b = t_ordy[1];

  logic [11:0] r_out [2];
  logic [2:0]  r_vld [2];
  logic        r_rdy [2];
  logic        r_drop[2];
  assign r_out[0] = {4'h0, out_a};  assign r_out[1] = out_b;
  assign r_vld[0] = {1'b0, vld_a};  assign r_vld[1] = vld_b;
  assign r_rdy[0] = rdy_a;          assign r_rdy[1] = rdy_b;
  assign r_drop[0] = drop_a;        assign r_drop[1] = drop_b;

`ifdef MUX_ROUTE_CNT_EN
  logic [15:0] cnt_a;
  logic [23:0] cnt_b;
  logic [23:0] r_cnt[2];
  assign r_cnt[0] = {8'h00, cnt_a};
  assign r_cnt[1] = cnt_b;
`endif

  mux_route_reg #(.SIZE(4), .N_IN(2), .N_OUT(2)) dut_a (
    .clk_(clk), .rst_n_(rst_n), .inp_(inp_a), .sel_(sel_a), .dst_(dst_a),
    .valid_(t_val[0]), .ready_(rdy_a), .out_(out_a), .out_valid_(vld_a),
    .out_ready_(ordy_a), .drop_(drop_a)
`ifdef MUX_ROUTE_CNT_EN
    , .cnt_(cnt_a)
`endif
  );

  mux_route_reg #(.SIZE(4), .N_IN(3), .N_OUT(3)) dut_b (
    .clk_(clk), .rst_n_(rst_n), .inp_(inp_b), .sel_(sel_b), .dst_(dst_b),
    .valid_(t_val[1]), .ready_(rdy_b), .out_(out_b), .out_valid_(vld_b),
    .out_ready_(ordy_b), .drop_(drop_b)
`ifdef MUX_ROUTE_CNT_EN
    , .cnt_(cnt_b)
`endif
  );

  // ---------------- behavioural model ----------------
  int       n_in [2] = '{2, 3};
  int       n_out[2] = '{2, 3};
  int       m_data[2][3];
  bit       m_vld [2][3];
  bit       m_drop[2];
  int       m_cnt [2][3];

  function automatic bit m_ready(input int d);
    int ds;
    ds = int'(t_dst[d]);
    if (ds >= n_out[d]) return 1'b1;
    return !m_vld[d][ds] || t_ordy[d][ds];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_drop[d] = 1'b0;
        for (int j = 0; j < 3; j++) begin
          m_data[d][j] = 0; m_vld[d][j] = 1'b0; m_cnt[d][j] = 0;
        end
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        bit acc;
        int s, ds;
        acc = t_val[d] && m_ready(d);
        s   = int'(t_sel[d]);
        ds  = int'(t_dst[d]);
        m_drop[d] = acc && (ds >= n_out[d]);
        for (int j = 0; j < n_out[d]; j++) begin
          if (acc && ds == j) begin
            m_data[d][j] = (s < n_in[d]) ? int'(t_inp[d][s*4 +: 4]) : 0;
            m_vld[d][j]  = 1'b1;
            m_cnt[d][j]  = (m_cnt[d][j] + 1) % 256;
          end else if (t_ordy[d][j]) begin
            m_vld[d][j] = 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut=%0d t=%0t got=%0h want=%0h", nm, d, $time, act, exp);
    end
  endtask

  // Single compare process, mid-low-phase after inputs settle.
  always @(negedge clk) begin
    #3;
    if (run) begin
      for (int d = 0; d < 2; d++) begin
        chk("ready", d, 32'(r_rdy[d]), 32'(m_ready(d)));
        chk("drop", d, 32'(r_drop[d]), 32'(m_drop[d]));
        for (int j = 0; j < n_out[d]; j++) begin
          chk("slot_data", d, 32'(r_out[d][j*4 +: 4]), 32'(m_data[d][j]));
          chk("slot_valid", d, 32'(r_vld[d][j]), 32'(m_vld[d][j]));
`ifdef MUX_ROUTE_CNT_EN
          chk("slot_cnt", d, 32'(r_cnt[d][j*8 +: 8]), 32'(m_cnt[d][j]));
`endif
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drv(input int d, input logic [11:0] inp, input int sel, input int dst,
                     input bit val, input logic [2:0] ordy);
    t_inp[d] = inp; t_sel[d] = 2'(sel); t_dst[d] = 2'(dst); t_val[d] = val; t_ordy[d] = ordy;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) drv(d, 12'h0, 0, 0, 1'b0, 3'b000);
    #2 rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    run = 1'b1;
    chk("rst_out", 0, 32'(out_a), 32'h0);
    chk("rst_valid", 0, 32'(vld_a), 32'h0);
    chk("rst_ready", 0, 32'(rdy_a), 32'h1);
    chk("rst_drop", 0, 32'(drop_a), 32'h0);

    // first transfer: channel 1 (A) into slot 0
    drv(0, 12'h0A5, 1, 0, 1'b1, 3'b000);
    #1 chk("first_ready", 0, 32'(rdy_a), 32'h1);
    step();
    chk("first_data", 0, 32'(out_a[3:0]), 32'hA);
    chk("first_valid", 0, 32'(vld_a), 32'h1);

    // slot 0 full and not consumed -> back-pressure
    drv(0, 12'h0A5, 0, 0, 1'b1, 3'b000);
    #1 chk("bp_ready", 0, 32'(rdy_a), 32'h0);
    step();
    chk("bp_hold", 0, 32'(out_a[3:0]), 32'hA);
    drv(0, 12'h0A5, 0, 0, 1'b1, 3'b001);
    #1 chk("pass_ready", 0, 32'(rdy_a), 32'h1);
    step();
    chk("pass_data", 0, 32'(out_a[3:0]), 32'h5);
    chk("pass_valid", 0, 32'(vld_a[0]), 32'h1);

    // back-to-back alternating slots
    for (int i = 0; i < 6; i++) begin
      drv(0, {4'h0, 4'(i + 8), 4'(i)}, i % 2, i % 2, 1'b1, 3'b011);
      step();
      chk("b2b_data", 0, 32'(out_a[(i % 2)*4 +: 4]), 32'((i % 2) ? i + 8 : i));
      chk("b2b_valid", 0, 32'(vld_a[i % 2]), 32'h1);
    end
    drv(0, 12'h0, 0, 0, 1'b0, 3'b011);

    // 3x3 build: out-of-range sel and dst
    drv(1, 12'h987, 0, 1, 1'b1, 3'b000);
    step();
    chk("b_load", 1, 32'(out_b[7:4]), 32'h7);
    drv(1, 12'h987, 3, 1, 1'b1, 3'b010);
    step();
    chk("b_sel_oor", 1, 32'(out_b[7:4]), 32'h0);
    chk("b_sel_oor_vld", 1, 32'(vld_b[1]), 32'h1);
    drv(1, 12'h987, 2, 3, 1'b1, 3'b000);
    #1 chk("b_dst_oor_rdy", 1, 32'(rdy_b), 32'h1);
    step();
    chk("b_drop", 1, 32'(drop_b), 32'h1);
    chk("b_drop_out", 1, 32'(out_b), 32'h0);
    chk("b_drop_vld", 1, 32'(vld_b), 32'b010);
    drv(1, 12'h0, 0, 0, 1'b0, 3'b000);
    step();
    chk("b_drop_pulse", 1, 32'(drop_b), 32'h0);

    // asynchronous reset while slots are full
    drv(0, 12'h0C3, 1, 0, 1'b1, 3'b000);
    step();
    drv(0, 12'h0C3, 0, 1, 1'b1, 3'b000);
    step();
    drv(0, 12'h0, 0, 0, 1'b0, 3'b000);
    chk("pre_rst_out", 0, 32'(out_a), 32'h3C);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out", 0, 32'(out_a), 32'h0);
    chk("async_vld", 0, 32'(vld_a), 32'h0);
    chk("async_vld_b", 1, 32'(vld_b), 32'h0);
    step();
    rst_n = 1'b1;
    chk("post_rst_ready", 0, 32'(rdy_a), 32'h1);

    // randomized traffic on both instances
    repeat (3000) begin
      for (int d = 0; d < 2; d++) begin
        int smax;
        smax = (d == 0) ? 1 : 3;
        drv(d, 12'($urandom), $urandom_range(0, smax), $urandom_range(0, smax),
            ($urandom_range(0, 3) != 0), 3'($urandom));
      end
      step();
    end

    for (int d = 0; d < 2; d++) drv(d, 12'h0, 0, 0, 1'b0, 3'b000);
    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
